// File: rtl/screen_coord_gen.sv
// XVGA raster generator: horizontal/vertical counters, centred y-up world
// coordinates and sync/blank outputs delayed to match downstream pixel stages.
module screen_coord_gen #(
    parameter int   H_ACTIVE    = 1024,
    parameter int   H_FP        = 24,
    parameter int   H_SYNC      = 136,
    parameter int   H_BP        = 160,
    parameter int   V_ACTIVE    = 768,
    parameter int   V_FP        = 3,
    parameter int   V_SYNC      = 6,
    parameter int   V_BP        = 29,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   ORIGIN_X    = 512,
    parameter int   ORIGIN_Y    = 767,
    parameter int   SYNC_DELAY  = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [10:0]        hcount,
    output logic [9:0]         vcount,
    output logic signed [11:0] x_value,
    output logic signed [11:0] y_value,
    output logic               blank,
    output logic               frame_start,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] ORG_X    = 12'(ORIGIN_X);
    localparam logic [11:0] ORG_Y    = 12'(ORIGIN_Y);

    logic [10:0]        h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic signed [11:0] x_q, x_d;
    logic signed [11:0] y_q, y_d;
    logic               blank_q, blank_d;
    logic               fs_q, fs_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               h_wrap;

    // Everything is derived from the next counter values so that all
    // per-pixel outputs sit in the same register stage as the counters.
    always_comb begin
        h_wrap  = (h_q == H_LAST);
        h_d     = h_wrap ? 11'd0 : h_q + 11'd1;
        v_d     = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        x_d     = {1'b0, h_d} - ORG_X;
        y_d     = ORG_Y - {2'b00, v_d};
        blank_d = (h_d >= H_ACT_W) || (v_d >= V_ACT_W);
        fs_d    = (h_d == 11'd0) && (v_d == 10'd0);
        hs_d    = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_d    = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= 11'd0;
            v_q     <= 10'd0;
            x_q     <= 12'd0 - ORG_X;
            y_q     <= ORG_Y;
            blank_q <= 1'b0;
            fs_q    <= 1'b1;
            hs_q    <= ~SYNC_ACTIVE;
            vs_q    <= ~SYNC_ACTIVE;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign x_value     = x_q;
    assign y_value     = y_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync_out = hs_q;
            assign vsync_out = vs_q;
            assign blank_out = blank_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q;
            logic [SYNC_DELAY-1:0] vs_pipe_q;
            logic [SYNC_DELAY-1:0] bl_pipe_q;

            // Stages reset to "blanked, sync idle" so the outputs stay quiet
            // until real pixels have propagated through.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
                    vs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
                    bl_pipe_q <= '1;
                end else begin
                    hs_pipe_q[0] <= hs_q;
                    vs_pipe_q[0] <= vs_q;
                    bl_pipe_q[0] <= blank_q;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                        bl_pipe_q[i] <= bl_pipe_q[i-1];
                    end
                end
            end

            assign hsync_out = hs_pipe_q[SYNC_DELAY-1];
            assign vsync_out = vs_pipe_q[SYNC_DELAY-1];
            assign blank_out = bl_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_screen_coord_gen.sv
// Directed bench: default-timing instances (delay 1/2/0) plus a shrunken-frame
// instance so vertical sync, frame wrap and the centre pixel are reachable.
module tb_screen_coord_gen;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int fs0_cnt = 0;
    int fs1_cnt = 0;
    int fs1_last = -1;
    int fs1_period = 0;

    logic [10:0] hc0, hc1, hc2, hc3;
    logic [9:0]  vc0, vc1, vc2, vc3;
    logic signed [11:0] x0, x1, x2, x3, y0, y1, y2, y3;
    logic bl0, bl1, bl2, bl3, fs0, fs1, fs2, fs3;
    logic hs0, hs1, hs2, hs3, vs0, vs1, vs2, vs3, bo0, bo1, bo2, bo3;

    screen_coord_gen #(.SYNC_DELAY(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .hcount(hc0), .vcount(vc0),
        .x_value(x0), .y_value(y0), .blank(bl0), .frame_start(fs0),
        .hsync_out(hs0), .vsync_out(vs0), .blank_out(bo0));

    // H_TOTAL=104, V_TOTAL=23, vsync lines 15..20, centre at (32,11)
    screen_coord_gen #(.H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(16),
                       .V_ACTIVE(12), .V_FP(3), .V_SYNC(6), .V_BP(2),
                       .ORIGIN_X(32), .ORIGIN_Y(11), .SYNC_DELAY(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .hcount(hc1), .vcount(vc1),
        .x_value(x1), .y_value(y1), .blank(bl1), .frame_start(fs1),
        .hsync_out(hs1), .vsync_out(vs1), .blank_out(bo1));

    screen_coord_gen #(.SYNC_DELAY(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .hcount(hc2), .vcount(vc2),
        .x_value(x2), .y_value(y2), .blank(bl2), .frame_start(fs2),
        .hsync_out(hs2), .vsync_out(vs2), .blank_out(bo2));

    screen_coord_gen #(.SYNC_DELAY(0)) dut3 (
        .clock(clock), .reset_n(reset_n), .hcount(hc3), .vcount(vc3),
        .x_value(x3), .y_value(y3), .blank(bl3), .frame_start(fs3),
        .hsync_out(hs3), .vsync_out(vs3), .blank_out(bo3));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // k = number of rising edges since reset release; sampled on negedge
    task automatic goto(input int target);
        while (k < target) begin
            @(negedge clock);
            k++;
            if (fs0 === 1'b1) fs0_cnt++;
            if (fs1 === 1'b1) begin
                fs1_cnt++;
                if (fs1_last >= 0) fs1_period = k - fs1_last;
                fs1_last = k;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_hcount", hc0, 0);
        check("rst_vcount", vc0, 0);
        check("rst_x", x0, -512);
        check("rst_y", y0, 767);
        check("rst_blank", bl0, 0);
        check("rst_fs", fs0, 1);
        check("rst_hsync_out", hs0, 1);
        check("rst_vsync_out", vs0, 1);
        check("rst_blank_out", bo0, 1);
        reset_n = 1'b1;

        goto(1);
        check("k1_hcount", hc0, 1);
        check("k1_x", x0, -511);
        check("k1_fs", fs0, 0);
        check("k1_blank_out_d1", bo0, 0);
        check("k1_vsync_out", vs0, 1);
        check("k1_blank_out_d2", bo2, 1);
        goto(2);
        check("k2_blank_out_d2", bo2, 0);

        goto(1023);
        check("h1023_blank", bl0, 0);
        check("h1023_blank_out_d0", bo3, 0);
        goto(1024);
        check("h1024_blank", bl0, 1);
        check("h1024_blank_out_d1", bo0, 0);
        check("h1024_blank_out_d0", bo3, 1);
        check("h1024_blank_out_d2", bo2, 0);
        goto(1025);
        check("h1025_blank_out_d1", bo0, 1);
        check("h1025_blank_out_d2", bo2, 0);
        goto(1026);
        check("h1026_blank_out_d2", bo2, 1);

        goto(1047);
        check("h1047_hsync_d0", hs3, 1);
        goto(1048);
        check("h1048_hsync_d0", hs3, 0);
        check("h1048_hsync_d1", hs0, 1);
        check("h1048_hsync_d2", hs2, 1);
        goto(1049);
        check("h1049_hsync_d1", hs0, 0);
        check("h1049_hsync_d2", hs2, 1);
        goto(1050);
        check("h1050_hsync_d2", hs2, 0);

        goto(1176);
        check("centre_hcount", hc1, 32);
        check("centre_vcount", vc1, 11);
        check("centre_x", x1, 0);
        check("centre_y", y1, 0);
        check("centre_blank", bl1, 0);
        check("centre_hsync_out", hs1, 1);
        check("centre_blank_out", bo1, 0);

        goto(1183);
        check("h1183_hsync_d0", hs3, 0);
        goto(1184);
        check("h1184_hsync_d0", hs3, 1);

        goto(1343);
        check("h1343_hcount", hc0, 1343);
        check("h1343_vcount", vc0, 0);
        check("h1343_x", x0, 831);
        goto(1344);
        check("l1_hcount", hc0, 0);
        check("l1_vcount", vc0, 1);
        check("l1_y", y0, 766);
        check("l1_d2_hcount", hc2, 0);
        check("l1_d2_vcount", vc2, 1);
        check("l1_d2_x", x2, -512);
        check("l1_d2_y", y2, 766);
        check("l1_d2_blank", bl2, 0);
        check("l1_d2_fs", fs2, 0);
        check("l1_d2_vsync_out", vs2, 1);
        check("l1_d0_hcount", hc3, 0);
        check("l1_d0_vcount", vc3, 1);
        check("l1_d0_x", x3, -512);
        check("l1_d0_y", y3, 766);
        check("l1_d0_blank", bl3, 0);
        check("l1_d0_fs", fs3, 0);
        check("l1_d0_vsync_out", vs3, 1);

        goto(1560);
        check("v14_vsync_out", vs1, 1);
        goto(1561);
        check("v15_vsync_out", vs1, 0);
        goto(2184);
        check("v20_vsync_out", vs1, 0);
        goto(2185);
        check("v21_vsync_out", vs1, 1);

        goto(2391);
        check("fw_pre_hcount", hc1, 103);
        check("fw_pre_vcount", vc1, 22);
        check("fw_pre_fs", fs1, 0);
        goto(2392);
        check("fw_hcount", hc1, 0);
        check("fw_vcount", vc1, 0);
        check("fw_x", x1, -32);
        check("fw_y", y1, 11);
        check("fw_fs", fs1, 1);
        goto(2393);
        check("fw_post_fs", fs1, 0);
        check("fw_post_hcount", hc1, 1);

        goto(8063);
        check("lw_pre_hcount", hc0, 1343);
        check("lw_pre_vcount", vc0, 5);
        goto(8064);
        check("lw_hcount", hc0, 0);
        check("lw_vcount", vc0, 6);
        check("lw_x", x0, -512);
        check("lw_y", y0, 761);
        check("lw_blank", bl0, 0);
        check("fs_count_full", fs0_cnt, 0);
        check("fs_count_small", fs1_cnt, 3);
        check("fs_period_small", fs1_period, 2392);

        goto(8500);
        reset_n = 1'b0;
        #1;
        check("mrst_hcount", hc0, 0);
        check("mrst_vcount", vc0, 0);
        check("mrst_x", x0, -512);
        check("mrst_y", y0, 767);
        check("mrst_fs", fs0, 1);
        check("mrst_hsync_out", hs0, 1);
        check("mrst_vsync_out", vs0, 1);
        check("mrst_blank_out", bo0, 1);
        repeat (3) @(negedge clock);
        check("mrst_hold_hcount", hc0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("mrel_hcount", hc0, 1);
        check("mrel_vcount", vc0, 0);
        check("mrel_x", x0, -511);
        check("mrel_fs", fs0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
